conv_io_ctrl: RTL
=================

# conv_io_ctrl

Host-side protocol controller for the 4-lane 5x5 convolution engine. It captures the serial 25-entry filter-coefficient stream and serves coefficients to the MAC core. It accepts the four lanes' raw accumulator results, clamps them to 8-bit pixels, and presents them on the `out_pixel0..3`/`out_valid` interface, one pulse per raster position. It sits between the testbench/host pins and the MAC datapath; the host consumes 64 rows x 256 columns of pulses, four pixels each.

## Interface
- `ACC_W`, 16: signed accumulator width per lane.
- `N_COEF`, 25: coefficients per filter (5x5).
- `N_OUT`, 16384: output pulses per frame (64 x 256).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: one clock; reset is asynchronous and active-low.
- `start` in 1: frame enable; held high for the whole frame.
- `fc_valid` in 1: coefficient strobe.
- `fc` in 8: signed coefficient, row-major order [0][0]..[4][4].
- `coef_rd_idx` in 5: MAC-side coefficient read address, 0..24.
- `coef_rd_data` out 8: signed coefficient at `coef_rd_idx`; combinational read; 0 for idx > 24.
- `coef_loaded` out 1: all 25 coefficients captured.
- `acc_valid` in 1: lane results valid.
- `acc_ready` out 1: controller can accept lane results.
- `acc0`..`acc3` in ACC_W: signed lane accumulators for rows i, i+64, i+128, i+192.
- `out_pixel0`..`out_pixel3` out 8: clamped pixels.
- `out_valid` out 1: one-cycle pulse per output position.
- `done` out 1: frame complete.

## Operation
- States:
  - IDLE: waits for `start`=1, then goes to LOAD.
  - LOAD: each cycle with `fc_valid`=1 writes `fc` to coef[cidx] and increments cidx. The write with cidx=24 sets `coef_loaded` and moves to RUN.
  - RUN: accepts and emits results. Moves to DONE when the emitted count reaches N_OUT.
  - DONE: `done`=1. When `start`=0, goes to IDLE and clears `done`; `coef_loaded` stays set.
- `fc_valid` outside LOAD is ignored. In LOAD, cycles with `fc_valid`=0 hold cidx; gaps are allowed.
- `start`=0 in LOAD or RUN aborts to IDLE:
  - clears cidx, counters, FIFO and `coef_loaded`;
  - forces `out_valid`=0;
  - leaves pixel registers unchanged.
- Entering LOAD from IDLE clears `coef_loaded` and cidx; a new frame reloads the coefficients.
- Clamp per lane, applied at FIFO push:
  - acc < 0 gives 0;
  - acc > 255 gives 255;
  - otherwise acc[7:0].
- Result FIFO: 2 entries x 32 bits.
  - `acc_ready` = (state==RUN) && (FIFO count < 2) && (accepted count < N_OUT), all from registered values.
  - A push happens on `acc_valid` && `acc_ready`. A pop in the same cycle does not raise `acc_ready` that cycle.
- Accepted count and emitted count are 15 bits each. Results offered after N_OUT accepts are not taken (`acc_ready`=0).

## Timing
- Reset values: `coef_rd_data` follows the cleared array (0). All other outputs are 0: `coef_loaded`, `acc_ready`, `out_pixel0..3`, `out_valid`, `done`. The coefficient array is cleared to 0.
- IDLE to LOAD takes 1 cycle after `start` is sampled high. The first `fc_valid` may arrive in the cycle after LOAD is entered. An `fc_valid` in the same cycle as the IDLE-to-LOAD transition is not captured.
- `coef_loaded` rises on the edge that captures coefficient 24. `acc_ready` can be high from the next cycle.
- Emission pipeline:
  - Edge E: FIFO head pops into the pixel registers. This happens only when `out_valid`=0 and the FIFO is non-empty.
  - Edge E+1: `out_valid` goes to 1.
  - Edge E+2: `out_valid` goes to 0. The next pop may occur on this same edge.
- Pixels therefore change only while `out_valid`=0, and stay stable through the pulse and until the next pop.
- Minimum pulse period is 2 cycles. Push-to-pulse latency on an empty FIFO is 2 cycles: push edge P, pop at P+1, `out_valid` high after P+2.
- The pulse is counted at the edge that raises `out_valid`. When the count reaches N_OUT, the state moves to DONE on that edge, so `done` rises with the last pulse and `out_valid` falls on the next edge.
- Asynchronous reset mid-frame returns to IDLE with all reset values immediately.

## Test plan
- Coefficient load: reset, `start`=1, then 25 cycles of `fc`=-1 with `fc`=24 at index 12 -> `coef_loaded` rises on the 25th capture; `coef_rd_data` reads 0xFF for idx 0 and 0x18 for idx 12; idx 31 reads 0.
- Clamp: acc0..3 = -6120, 300, 255, 0 -> pixels 0, 255, 255, 0, visible one cycle before the `out_valid` pulse and stable during it.
- Backpressure: `acc_valid` held high continuously -> `acc_ready` toggles so that pushes average 1 per 2 cycles; `out_valid` has a 1-cycle-high/1-cycle-low pattern; no result is lost or duplicated (check with a sequence counter in the acc values).
- Frame end: 16384 accepted results -> exactly 16384 `out_valid` rising edges, `done`=1 with the last pulse, `acc_ready` stays 0 afterwards; dropping `start` returns the state to IDLE and `done` to 0.
- Gapped coefficients: `fc_valid` with idle gaps, plus an extra `fc_valid` during RUN -> exactly 25 captures; coefficients are unchanged by the extra strobe.
- Abort/reset: `start`=0 after 100 pulses -> `out_valid`=0, `coef_loaded`=0, a new start requires a reload. Separately, `rst_n` pulsed low mid-RUN -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/conv_io_ctrl_if.sv
// Lane-result handshake and clamped pixel output bundle for conv_io_ctrl.
// The host side drives lane accumulators; the controller returns ready and pixels.
interface conv_io_ctrl_if #(
  parameter int ACC_W = 16
);
  logic             acc_valid;
  logic             acc_ready;
  logic [ACC_W-1:0] acc0;
  logic [ACC_W-1:0] acc1;
  logic [ACC_W-1:0] acc2;
  logic [ACC_W-1:0] acc3;
  logic [7:0]       out_pixel0;
  logic [7:0]       out_pixel1;
  logic [7:0]       out_pixel2;
  logic [7:0]       out_pixel3;
  logic             out_valid;

  modport master (
    output acc_valid, acc0, acc1, acc2, acc3,
    input  acc_ready, out_pixel0, out_pixel1, out_pixel2, out_pixel3, out_valid
  );

  modport slave (
    input  acc_valid, acc0, acc1, acc2, acc3,
    output acc_ready, out_pixel0, out_pixel1, out_pixel2, out_pixel3, out_valid
  );
endinterface

// File: rtl/conv_io_ctrl.sv
// Host-side controller for the 4-lane 5x5 convolution engine: captures the
// 25-entry coefficient stream, clamps lane results and emits one pulse per position.
module conv_io_ctrl #(
  parameter int ACC_W  = 16,
  parameter int N_COEF = 25,
  parameter int N_OUT  = 16384
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        fc_valid,
  input  logic [7:0]  fc,
  input  logic [4:0]  coef_rd_idx,
  output logic [7:0]  coef_rd_data,
  output logic        coef_loaded,
  output logic        done,
  conv_io_ctrl_if.slave acc_if
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  localparam logic [14:0] N_OUT_C  = 15'(N_OUT);
  localparam logic [14:0] LAST_OUT = 15'(N_OUT - 1);
  localparam logic [4:0]  LAST_IDX = 5'(N_COEF - 1);

  state_t      state, state_n;
  logic [7:0]  coef [N_COEF];
  logic [4:0]  cidx;
  logic [31:0] fifo [2];
  logic        wr_ptr, rd_ptr;
  logic [1:0]  fcnt;
  logic [14:0] acc_cnt, emit_cnt;
  logic        pend;
  logic        abort, enter_load, ld_wr, push, pop;

  // Sign bit forces 0; any set bit above bit 7 saturates to 255.
  function automatic logic [7:0] clamp(input logic [ACC_W-1:0] a);
    if (a[ACC_W-1])
      return '0;
    else if (|a[ACC_W-2:8])
      return '1;
    else
      return a[7:0];
  endfunction

  assign acc_if.acc_ready = (state == RUN) && (fcnt < 2'd2) && (acc_cnt < N_OUT_C);
  assign push         = acc_if.acc_valid && acc_if.acc_ready;
  // pend marks a popped entry whose pulse is raised on the next edge, so pops
  // can line up with the falling edge of the previous pulse.
  assign pop          = (state == RUN) && !pend && (fcnt != 2'd0);
  assign done         = (state == DONE);
  assign coef_rd_data = (coef_rd_idx <= LAST_IDX) ? coef[coef_rd_idx] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n    = state;
    abort      = 1'b0;
    enter_load = 1'b0;
    ld_wr      = 1'b0;
    unique case (state)
      IDLE: if (start) begin
        state_n    = LOAD;
        enter_load = 1'b1;
      end
      LOAD: if (!start) begin
        state_n = IDLE;
        abort   = 1'b1;
      end else if (fc_valid) begin
        ld_wr = 1'b1;
        if (cidx == LAST_IDX) state_n = RUN;
      end
      RUN: if (!start) begin
        state_n = IDLE;
        abort   = 1'b1;
      end else if (pend && (emit_cnt == LAST_OUT)) begin
        state_n = DONE;
      end
      DONE: if (!start) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_COEF; i++) coef[i] <= '0;
      fifo[0]           <= '0;
      fifo[1]           <= '0;
      cidx              <= '0;
      coef_loaded       <= 1'b0;
      wr_ptr            <= 1'b0;
      rd_ptr            <= 1'b0;
      fcnt              <= '0;
      acc_cnt           <= '0;
      emit_cnt          <= '0;
      pend              <= 1'b0;
      acc_if.out_valid  <= 1'b0;
      acc_if.out_pixel0 <= '0;
      acc_if.out_pixel1 <= '0;
      acc_if.out_pixel2 <= '0;
      acc_if.out_pixel3 <= '0;
    end else if (abort) begin
      cidx             <= '0;
      coef_loaded      <= 1'b0;
      wr_ptr           <= 1'b0;
      rd_ptr           <= 1'b0;
      fcnt             <= '0;
      acc_cnt          <= '0;
      emit_cnt         <= '0;
      pend             <= 1'b0;
      acc_if.out_valid <= 1'b0;
    end else begin
      if (enter_load) begin
        cidx        <= '0;
        coef_loaded <= 1'b0;
        acc_cnt     <= '0;
        emit_cnt    <= '0;
      end
      if (ld_wr) begin
        coef[cidx] <= fc;
        cidx       <= cidx + 5'd1;
        if (cidx == LAST_IDX) coef_loaded <= 1'b1;
      end
      if (push) begin
        fifo[wr_ptr] <= {clamp(acc_if.acc3), clamp(acc_if.acc2),
                         clamp(acc_if.acc1), clamp(acc_if.acc0)};
        wr_ptr       <= ~wr_ptr;
        acc_cnt      <= acc_cnt + 15'd1;
      end
      if (pop) begin
        {acc_if.out_pixel3, acc_if.out_pixel2,
         acc_if.out_pixel1, acc_if.out_pixel0} <= fifo[rd_ptr];
        rd_ptr <= ~rd_ptr;
      end
      unique case ({push, pop})
        2'b10:   fcnt <= fcnt + 2'd1;
        2'b01:   fcnt <= fcnt - 2'd1;
        default: fcnt <= fcnt;
      endcase
      pend             <= pop;
      acc_if.out_valid <= pend;
      if (pend) emit_cnt <= emit_cnt + 15'd1;
    end
  end
endmodule
